// File: rtl/ascensor_pkg.sv
// Shared types and width helpers for the N-floor elevator controller.
// The EMERGENCY state code exists only when ASCENSOR_EMERGENCY_EN is defined.
package ascensor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE_UP   = 3'd1,
    ST_MOVE_DOWN = 3'd2,
    ST_DOOR_OPEN = 3'd3,
    ST_HOLD      = 3'd4
`ifdef ASCENSOR_EMERGENCY_EN
    , ST_EMERGENCY = 3'd5
`endif
  } estado_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // A two-floor car still needs one bit of floor index.
  function automatic int floor_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int timer_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/temporizador_ascensor.sv
// Restartable down-counter timing travel and door dwell; t_expired is high while the count is zero.
module temporizador_ascensor #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_timer,
  input  logic             restart_timer,
  input  logic             hold,
  input  logic [CNT_W-1:0] load_val,
  output logic             t_expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_timer || restart_timer) begin
      cnt_d = load_val;
    end else if (!hold && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign t_expired = (cnt_q == '0);

endmodule

// File: rtl/controlador_ascensor_n.sv
// N-floor elevator controller: call latch, directional-sweep scheduler and door/motor FSM.
// Defining ASCENSOR_EMERGENCY_EN adds the emergency_stop input and the EMERGENCY state.
module controlador_ascensor_n
  import ascensor_pkg::*;
#(
  parameter int NUM_FLOORS    = 4,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_FLOORS-1:0]                 call_req,
  input  logic                                  sensor_puerta,
  input  logic                                  sensor_sobrepeso,
`ifdef ASCENSOR_EMERGENCY_EN
  input  logic                                  emergency_stop,
`endif
  output logic [floor_width(NUM_FLOORS)-1:0]    floor,
  output logic [2:0]                            state,
  output logic                                  motor_up,
  output logic                                  motor_down,
  output logic                                  door_open,
  output logic [NUM_FLOORS-1:0]                 pending
);

  localparam int FLOOR_W = floor_width(NUM_FLOORS);
  localparam int CNT_W   = timer_width(TRAVEL_CYCLES, DOOR_CYCLES);
  // Loading N-1 makes a phase last exactly N cycles, since the FSM acts on the zero cycle.
  localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);

  estado_t                state_q, state_d;
  logic [FLOOR_W-1:0]     floor_q, floor_d;
  logic                   dir_q, dir_d;
  logic [NUM_FLOORS-1:0]  pending_q, pending_d;
  logic                   motor_up_q, motor_down_q, door_open_q;

  logic                   start_t, restart_t, hold_t, t_expired;
  logic [CNT_W-1:0]       load_val;
  logic [NUM_FLOORS-1:0]  latch_mask, arrive_mask;
  logic [FLOOR_W-1:0]     floor_up, floor_dn;
  logic                   ahead_q, behind_q, sched_go, sched_dir;
  estado_t                sched_state;

  function automatic logic calls_beyond(input logic [NUM_FLOORS-1:0] m,
                                        input logic [FLOOR_W-1:0] f, input logic d);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (m[i] && (((d == DIR_UP) && (i > int'(f))) || ((d == DIR_DOWN) && (i < int'(f))))) r = 1'b1;
    end
    return r;
  endfunction

  assign floor_up    = floor_q + FLOOR_W'(1);
  assign floor_dn    = floor_q - FLOOR_W'(1);
  assign arrive_mask = pending_q | call_req;
  assign ahead_q     = calls_beyond(pending_q, floor_q, dir_q);
  assign behind_q    = calls_beyond(pending_q, floor_q, ~dir_q);
  assign sched_go    = ahead_q | behind_q;
  assign sched_dir   = ahead_q ? dir_q : ~dir_q;
  assign sched_state = (sched_dir == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    start_t    = 1'b0;
    restart_t  = 1'b0;
    hold_t     = 1'b0;
    load_val   = DOOR_LOAD;
    latch_mask = call_req;
    pending_d  = pending_q;

    case (state_q)
      ST_IDLE: begin
        if (call_req[floor_q]) begin
          state_d = ST_DOOR_OPEN;
          start_t = 1'b1;
        end else if (sched_go) begin
          state_d  = sched_state;
          dir_d    = sched_dir;
          start_t  = 1'b1;
          load_val = TRAVEL_LOAD;
        end
      end
      ST_MOVE_UP: begin
        if (t_expired) begin
          if (int'(floor_q) >= NUM_FLOORS - 1) begin
            state_d = ST_IDLE;
          end else begin
            floor_d = floor_up;
            if (arrive_mask[floor_up]) begin
              state_d = ST_DOOR_OPEN;
              start_t = 1'b1;
            end else if (calls_beyond(pending_q, floor_up, DIR_UP)) begin
              restart_t = 1'b1;
              load_val  = TRAVEL_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_MOVE_DOWN: begin
        if (t_expired) begin
          if (floor_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            floor_d = floor_dn;
            if (arrive_mask[floor_dn]) begin
              state_d = ST_DOOR_OPEN;
              start_t = 1'b1;
            end else if (calls_beyond(pending_q, floor_dn, DIR_DOWN)) begin
              restart_t = 1'b1;
              load_val  = TRAVEL_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_DOOR_OPEN: begin
        // Overweight beats obstruction, which beats a same-floor call, which beats expiry.
        if (sensor_sobrepeso) begin
          state_d = ST_HOLD;
        end else if (sensor_puerta || call_req[floor_q]) begin
          restart_t = 1'b1;
        end else if (t_expired) begin
          if (sched_go) begin
            state_d  = sched_state;
            dir_d    = sched_dir;
            start_t  = 1'b1;
            load_val = TRAVEL_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        hold_t = 1'b1;
        if (!sensor_sobrepeso) begin
          state_d = ST_DOOR_OPEN;
          start_t = 1'b1;
        end
      end
`ifdef ASCENSOR_EMERGENCY_EN
      ST_EMERGENCY: begin
        if (!emergency_stop) begin
          state_d = ST_DOOR_OPEN;
          start_t = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef ASCENSOR_EMERGENCY_EN
    if (emergency_stop) begin
      state_d   = ST_EMERGENCY;
      floor_d   = floor_q;
      dir_d     = dir_q;
      start_t   = 1'b1;
      restart_t = 1'b0;
      hold_t    = 1'b0;
      load_val  = '0;
    end
`endif

    // A call for the floor the car is parked at is served by the door, never latched.
    if ((state_q == ST_IDLE) || (state_q == ST_DOOR_OPEN) || (state_q == ST_HOLD)) begin
      latch_mask[floor_q] = 1'b0;
    end
    pending_d = pending_q | latch_mask;
    if ((state_d == ST_DOOR_OPEN) && (state_q != ST_DOOR_OPEN)) begin
      pending_d[floor_d] = 1'b0;
    end
`ifdef ASCENSOR_EMERGENCY_EN
    if (emergency_stop || (state_q == ST_EMERGENCY)) pending_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      floor_q      <= '0;
      dir_q        <= DIR_UP;
      pending_q    <= '0;
      motor_up_q   <= 1'b0;
      motor_down_q <= 1'b0;
      door_open_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      dir_q        <= dir_d;
      pending_q    <= pending_d;
      motor_up_q   <= (state_d == ST_MOVE_UP);
      motor_down_q <= (state_d == ST_MOVE_DOWN);
      door_open_q  <= (state_d == ST_DOOR_OPEN) || (state_d == ST_HOLD);
    end
  end

  temporizador_ascensor #(.CNT_W(CNT_W)) u_temporizador (
    .clk           (clk),
    .reset         (reset),
    .start_timer   (start_t),
    .restart_timer (restart_t),
    .hold          (hold_t),
    .load_val      (load_val),
    .t_expired     (t_expired)
  );

  assign floor      = floor_q;
  assign state      = state_q;
  assign pending    = pending_q;
  assign motor_up   = motor_up_q;
  assign motor_down = motor_down_q;
  assign door_open  = door_open_q;

endmodule

// File: tb/tb_controlador_ascensor_n.sv
// Bench for controlador_ascensor_n: hand-computed table, corner sequences, and random traffic
// checked every cycle against a phase-countdown model of the elevator rules.
module tb_controlador_ascensor_n;

  localparam int NF = 4;
  localparam int TRAVEL = 16;
  localparam int DOOR = 8;
  localparam int FW = 2;
  localparam int W = FW + 6 + NF;

  logic clk = 1'b0;
  logic reset;
  logic [NF-1:0] call_req;
  logic sensor_puerta, sensor_sobrepeso, estop;
  logic [FW-1:0] floor;
  logic [2:0] state;
  logic motor_up, motor_down, door_open;
  logic [NF-1:0] pending;

  always #5 clk = ~clk;

  controlador_ascensor_n #(.NUM_FLOORS(NF), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
    .clk              (clk),
    .reset            (reset),
    .call_req         (call_req),
    .sensor_puerta    (sensor_puerta),
    .sensor_sobrepeso (sensor_sobrepeso),
`ifdef ASCENSOR_EMERGENCY_EN
    .emergency_stop   (estop),
`endif
    .floor            (floor),
    .state            (state),
    .motor_up         (motor_up),
    .motor_down       (motor_down),
    .door_open        (door_open),
    .pending          (pending)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_left counts the clock edges still to go in the current travel leg or dwell.
  int m_state, m_floor, m_dir, m_left;
  logic [NF-1:0] m_pend;

  task automatic model_reset();
    m_state = 0; m_floor = 0; m_dir = 0; m_left = 0; m_pend = '0;
  endtask

  function automatic bit calls_beyond(input int f, input int d);
    for (int i = 0; i < NF; i++) begin
      if (m_pend[i] && ((d == 0 && i > f) || (d == 1 && i < f))) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic sched(inout int ns, inout int nd, inout int nl);
    if (calls_beyond(m_floor, m_dir)) begin
      ns = (m_dir == 0) ? 1 : 2; nl = TRAVEL;
    end else if (calls_beyond(m_floor, 1 - m_dir)) begin
      nd = 1 - m_dir; ns = (nd == 0) ? 1 : 2; nl = TRAVEL;
    end else begin
      ns = 0;
    end
  endtask

  task automatic model_step(input logic [NF-1:0] c, input logic p, input logic s, input logic e);
    int ns, nf, nd, nl;
    logic [NF-1:0] np;
    ns = m_state; nf = m_floor; nd = m_dir; nl = m_left; np = m_pend;
    for (int i = 0; i < NF; i++) begin
      if (c[i] && m_state != 5 && !(i == m_floor && (m_state == 0 || m_state == 3 || m_state == 4)))
        np[i] = 1'b1;
    end
    case (m_state)
      0: if (c[m_floor]) begin ns = 3; nl = DOOR; end else sched(ns, nd, nl);
      1, 2: begin
        nl = m_left - 1;
        if (nl == 0) begin
          nf = m_floor + ((m_state == 1) ? 1 : -1);
          if (m_pend[nf] || c[nf]) begin ns = 3; nl = DOOR; end
          else if (calls_beyond(nf, (m_state == 1) ? 0 : 1)) nl = TRAVEL;
          else ns = 0;
        end
      end
      3: begin
        if (s) ns = 4;
        else if (p || c[m_floor]) nl = DOOR;
        else begin
          nl = m_left - 1;
          if (nl == 0) sched(ns, nd, nl);
        end
      end
      4: if (!s) begin ns = 3; nl = DOOR; end
      5: if (!e) begin ns = 3; nl = DOOR; end
      default: ns = 0;
    endcase
    if (e) begin ns = 5; nf = m_floor; nd = m_dir; np = '0; nl = 0; end
    if (ns == 3 && m_state != 3) np[nf] = 1'b0;
    m_state = ns; m_floor = nf; m_dir = nd; m_left = nl; m_pend = np;
  endtask

  function automatic logic [W-1:0] pack(input int st, input int fl, input logic [NF-1:0] p);
    logic mu, md, dr;
    mu = (st == 1); md = (st == 2); dr = (st == 3 || st == 4);
    return {FW'(fl), 3'(st), mu, md, dr, p};
  endfunction

  // ---------------- driver ----------------
  task automatic step_e(input logic [NF-1:0] c, input logic p, input logic s, input logic e);
    logic [W-1:0] exp_v;
    @(negedge clk);
    call_req = c; sensor_puerta = p; sensor_sobrepeso = s; estop = e;
    model_step(c, p, s, e);
    exp_q.push_back(pack(m_state, m_floor, m_pend));
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    check("cycle", 32'({floor, state, motor_up, motor_down, door_open, pending}), 32'(exp_v));
  endtask

  task automatic step(input logic [NF-1:0] c, input logic p, input logic s);
    step_e(c, p, s, 1'b0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [NF-1:0] call;
    logic          puerta;
    logic          sobre;
    int            cycles;
    int            st;
    int            fl;
    logic          door;
    logic [NF-1:0] pend;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [NF-1:0] c, input logic p, input logic s, input int n,
                     input int st, input int fl, input logic d, input logic [NF-1:0] pe);
    vec_t v;
    v.call = c; v.puerta = p; v.sobre = s; v.cycles = n;
    v.st = st; v.fl = fl; v.door = d; v.pend = pe;
    tbl.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input int st, input int fl, input logic d,
                               input logic [NF-1:0] pe);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".floor"}, 32'(floor), 32'(fl));
    check({tag, ".door"}, 32'(door_open), 32'(d));
    check({tag, ".motors"}, 32'({motor_up, motor_down}), 32'({st == 1, st == 2}));
    check({tag, ".pending"}, 32'(pending), 32'(pe));
  endtask

  logic sob_r;
  logic [NF-1:0] rc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; call_req = '0; sensor_puerta = 1'b0; sensor_sobrepeso = 1'b0; estop = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 0, 0, 1'b0, 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // call to top floor, same-floor reopen, obstruction, reverse trip with overweight hold
    add(4'b1000, 0, 0,  1, 0, 0, 0, 4'b1000);
    add(4'b0000, 0, 0,  1, 1, 0, 0, 4'b1000);
    add(4'b0000, 0, 0, 47, 1, 2, 0, 4'b1000);
    add(4'b0000, 0, 0,  1, 3, 3, 1, 4'b0000);
    add(4'b0000, 0, 0,  7, 3, 3, 1, 4'b0000);
    add(4'b0000, 0, 0,  1, 0, 3, 0, 4'b0000);
    add(4'b1000, 0, 0,  1, 3, 3, 1, 4'b0000);
    add(4'b0000, 0, 0,  3, 3, 3, 1, 4'b0000);
    add(4'b0000, 1, 0,  5, 3, 3, 1, 4'b0000);
    add(4'b0000, 0, 0,  7, 3, 3, 1, 4'b0000);
    add(4'b0000, 0, 0,  1, 0, 3, 0, 4'b0000);
    add(4'b0001, 0, 0,  1, 0, 3, 0, 4'b0001);
    add(4'b0000, 0, 0,  1, 2, 3, 0, 4'b0001);
    add(4'b0000, 0, 0, 48, 3, 0, 1, 4'b0000);
    add(4'b0000, 0, 0,  3, 3, 0, 1, 4'b0000);
    add(4'b0000, 0, 1, 20, 4, 0, 1, 4'b0000);
    add(4'b0000, 0, 0,  1, 3, 0, 1, 4'b0000);
    add(4'b0000, 0, 0,  7, 3, 0, 1, 4'b0000);
    add(4'b0000, 0, 0,  1, 0, 0, 0, 4'b0000);
    // call behind the car while it heads up: top floor served first, then sweep down
    add(4'b1000, 0, 0,  1, 0, 0, 0, 4'b1000);
    add(4'b0000, 0, 0,  1, 1, 0, 0, 4'b1000);
    add(4'b0000, 0, 0, 40, 1, 2, 0, 4'b1000);
    add(4'b0001, 0, 0,  1, 1, 2, 0, 4'b1001);
    add(4'b0000, 0, 0,  7, 3, 3, 1, 4'b0001);
    add(4'b0000, 0, 0,  8, 2, 3, 0, 4'b0001);
    add(4'b0000, 0, 0, 48, 3, 0, 1, 4'b0000);
    add(4'b0000, 0, 0,  8, 0, 0, 0, 4'b0000);
    // call for floor 1 arriving on the very edge the car reaches floor 1
    add(4'b0100, 0, 0,  1, 0, 0, 0, 4'b0100);
    add(4'b0000, 0, 0,  1, 1, 0, 0, 4'b0100);
    add(4'b0000, 0, 0, 15, 1, 0, 0, 4'b0100);
    add(4'b0010, 0, 0,  1, 3, 1, 1, 4'b0100);
    add(4'b0000, 0, 0,  8, 1, 1, 0, 4'b0100);
    add(4'b0000, 0, 0, 16, 3, 2, 1, 4'b0000);
    add(4'b0000, 0, 0,  8, 0, 2, 0, 4'b0000);

    for (int k = 0; k < tbl.size(); k++) begin
      for (int c = 0; c < tbl[k].cycles; c++) begin
        step((c == 0) ? tbl[k].call : '0, tbl[k].puerta, tbl[k].sobre);
      end
      check_outputs($sformatf("tbl%0d", k), tbl[k].st, tbl[k].fl, tbl[k].door, tbl[k].pend);
    end

    // asynchronous reset in the middle of a downward trip
    step(4'b0001, 0, 0);
    repeat (21) step('0, 0, 0);
    check_outputs("pre_reset", 2, 1, 1'b0, 4'b0001);
    #3 reset = 1'b1;
    #1 check_outputs("async_reset", 0, 0, 1'b0, 4'b0000);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    step('0, 0, 0);
    check_outputs("post_reset", 0, 0, 1'b0, 4'b0000);

`ifdef ASCENSOR_EMERGENCY_EN
    step(4'b1000, 0, 0);
    repeat (21) step('0, 0, 0);
    step_e('0, 0, 0, 1'b1);
    check_outputs("estop", 5, 1, 1'b0, 4'b0000);
    repeat (3) step_e(4'b0100, 0, 0, 1'b1);
    check_outputs("estop_hold", 5, 1, 1'b0, 4'b0000);
    step_e('0, 0, 0, 1'b0);
    check_outputs("estop_release", 3, 1, 1'b1, 4'b0000);
    repeat (8) step('0, 0, 0);
    check_outputs("estop_idle", 0, 1, 1'b0, 4'b0000);
`endif

    // random traffic against the model
    sob_r = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      rc = '0;
      if ($urandom_range(0, 7) == 0) rc = NF'($urandom_range(1, (1 << NF) - 1));
      if (sob_r) begin
        if ($urandom_range(0, 7) == 0) sob_r = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        sob_r = 1'b1;
      end
      step(rc, ($urandom_range(0, 15) == 0), sob_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
